// File: rtl/i2s_tx_fifo_serializer.sv
// Buffers {L,R} sample pairs in a small FIFO and serializes them as Philips-I2S.
// Output stays muted until the FIFO is primed to half full; an underflow re-mutes it.
module i2s_tx_fifo_serializer #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH = 32,
  parameter int unsigned BCK_HALF   = 4,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic                  AMCLK_i,
  input  logic                  ARST_i,
  input  logic [DATA_WIDTH-1:0] APSDATA_LEFT_i,
  input  logic [DATA_WIDTH-1:0] APSDATA_RIGHT_i,
  input  logic                  APDATA_VALID_i,
  output logic                  I2S_BCK,
  output logic                  I2S_WS,
  output logic                  I2S_DATA,
  output logic [FIFO_AW:0]      FIFO_LEVEL_o,
  output logic                  OVF_o,
  output logic                  UNF_o
);

  localparam int unsigned Depth     = 2 ** FIFO_AW;
  localparam int unsigned FrameBits = 2 * SLOT_WIDTH;
  localparam int unsigned BitW      = $clog2(FrameBits);
  localparam int unsigned DivW      = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
  localparam int unsigned FrameW    = 2 * DATA_WIDTH;

  localparam logic [FIFO_AW:0]   LevelOne   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   PrimeLevel = (FIFO_AW + 1)'(2 ** (FIFO_AW - 1));
  localparam logic [FIFO_AW:0]   FullLevel  = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW-1:0] PtrOne     = FIFO_AW'(1);
  localparam logic [BitW-1:0]    BitOne     = BitW'(1);
  localparam logic [BitW-1:0]    LastBit    = BitW'(FrameBits - 1);
  localparam logic [BitW-1:0]    SlotBits   = BitW'(SLOT_WIDTH);
  localparam logic [BitW-1:0]    DataBits   = BitW'(DATA_WIDTH);
  localparam logic [DivW-1:0]    DivOne     = DivW'(1);
  localparam logic [DivW-1:0]    DivLast    = DivW'(BCK_HALF - 1);

  typedef enum logic {StPrime, StRun} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_cnt_q, div_cnt_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                bck_q, bck_d;
  logic                ws_q, ws_d;
  logic                data_q, data_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [FrameW-1:0]   frame_q, frame_d;

  logic [FrameW-1:0]   mem_q [Depth];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;

  logic                tick, fall_tick, frame_start;
  logic                pop, push_ok;
  logic [BitW-1:0]     slot_pos;
  logic [DATA_WIDTH-1:0] sample, sample_sh;

  assign tick        = (div_cnt_q == DivLast);
  assign fall_tick   = tick && bck_q;
  assign frame_start = fall_tick && (bit_cnt_q == LastBit);

  // Bit clock, frame position, frame fetch and serial data
  always_comb begin
    div_cnt_d = div_cnt_q + DivOne;
    bck_d     = bck_q;
    bit_cnt_d = bit_cnt_q;
    ws_d      = ws_q;
    data_d    = data_q;
    frame_d   = frame_q;
    state_d   = state_q;
    pop       = 1'b0;
    unf_d     = 1'b0;
    slot_pos  = '0;
    sample    = '0;
    sample_sh = '0;

    if (tick) begin
      div_cnt_d = '0;
      bck_d     = ~bck_q;
    end

    if (fall_tick) begin
      bit_cnt_d = (bit_cnt_q == LastBit) ? '0 : bit_cnt_q + BitOne;

      // The fetch must settle before the first bit of the new frame is chosen.
      if (frame_start) begin
        case (state_q)
          StPrime: begin
            frame_d = '0;
            if (count_q >= PrimeLevel) begin
              state_d = StRun;
              pop     = 1'b1;
              frame_d = mem_q[rd_ptr_q];
            end
          end
          StRun: begin
            if (count_q != '0) begin
              pop     = 1'b1;
              frame_d = mem_q[rd_ptr_q];
            end else begin
              frame_d = '0;
              unf_d   = 1'b1;
              state_d = StPrime;
            end
          end
          default: state_d = StPrime;
        endcase
      end

      ws_d      = (bit_cnt_d >= SlotBits);
      slot_pos  = ws_d ? (bit_cnt_d - SlotBits) : bit_cnt_d;
      sample    = ws_d ? frame_d[DATA_WIDTH-1:0] : frame_d[FrameW-1:DATA_WIDTH];
      sample_sh = sample << (slot_pos - BitOne);
      // Slot position 0 is the Philips one-BCK delay; positions past the sample are padding.
      data_d    = (slot_pos != '0 && slot_pos <= DataBits) ? sample_sh[DATA_WIDTH-1] : 1'b0;
    end
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot a push on full needs
  assign push_ok = APDATA_VALID_i && ((count_q != FullLevel) || pop);
  assign ovf_d   = APDATA_VALID_i && (count_q == FullLevel) && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + LevelOne;
      2'b01:   count_d = count_q - LevelOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge AMCLK_i) begin
    if (ARST_i) begin
      state_q   <= StPrime;
      div_cnt_q <= '0;
      bit_cnt_q <= LastBit;
      bck_q     <= 1'b0;
      ws_q      <= 1'b1;
      data_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      frame_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bck_q     <= bck_d;
      ws_q      <= ws_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      frame_q   <= frame_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they hold data.
  always_ff @(posedge AMCLK_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {APSDATA_LEFT_i, APSDATA_RIGHT_i};
    end
  end

  assign I2S_BCK      = bck_q;
  assign I2S_WS       = ws_q;
  assign I2S_DATA     = data_q;
  assign FIFO_LEVEL_o = count_q;
  assign OVF_o        = ovf_q;
  assign UNF_o        = unf_q;

endmodule

// File: tb/tb_i2s_tx_fifo_serializer.sv
// Directed bench for i2s_tx_fifo_serializer: frames pushed are queued as expectations and
// matched against frames decoded from the I2S pins.
module tb_i2s_tx_fifo_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] l_in = '0;
  logic [23:0] r_in = '0;
  logic        valid = 1'b0;
  logic        bck, ws, sdata, ovf, unf;
  logic [2:0]  level;

  always #5 clk = ~clk;

  i2s_tx_fifo_serializer #(
    .DATA_WIDTH(24),
    .SLOT_WIDTH(32),
    .BCK_HALF  (4),
    .FIFO_AW   (2)
  ) dut (
    .AMCLK_i        (clk),
    .ARST_i         (rst),
    .APSDATA_LEFT_i (l_in),
    .APSDATA_RIGHT_i(r_in),
    .APDATA_VALID_i (valid),
    .I2S_BCK        (bck),
    .I2S_WS         (ws),
    .I2S_DATA       (sdata),
    .FIFO_LEVEL_o   (level),
    .OVF_o          (ovf),
    .UNF_o          (unf)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  int unf_cnt = 0;
  int mute_cnt = 0;
  int data_ones = 0;
  logic [47:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Decoder/scoreboard: slot starts at the first BCK rise after a WS change
  initial begin
    logic        bck_prev;
    logic        ws_prev;
    logic        have_left;
    int          pos;
    logic [31:0] sh;
    logic [23:0] mon_left, mon_right;
    logic [47:0] want;
    bck_prev  = 1'b0;
    ws_prev   = 1'b1;
    have_left = 1'b0;
    pos       = -1;
    sh        = '0;
    mon_left  = '0;
    mon_right = '0;
    forever begin
      @(negedge clk);
      if (ovf) ovf_cnt++;
      if (unf) unf_cnt++;
      if (bck && !bck_prev) begin
        if (sdata) data_ones++;
        if (ws !== ws_prev) pos = 0;
        ws_prev = ws;
        if (pos >= 0) begin
          sh = {sh[30:0], sdata};
          pos++;
          if (pos == 32) begin
            pos = -1;
            chk("slot_pad_bits", {56'h0, sh[31], sh[6:0]}, 64'h0);
            if (!ws) begin
              mon_left  = sh[30:7];
              have_left = 1'b1;
            end else if (have_left) begin
              have_left = 1'b0;
              mon_right = sh[30:7];
              if (mon_left == 24'h0 && mon_right == 24'h0) begin
                mute_cnt++;
              end else if (exp_q.size() == 0) begin
                chk("unexpected_frame", {16'h0, mon_left, mon_right}, 64'h0);
              end else begin
                want = exp_q.pop_front();
                chk("frame_lr", {16'h0, mon_left, mon_right}, {16'h0, want});
              end
            end
          end
        end
      end
      bck_prev = bck;
    end
  end

  task automatic push(input logic [47:0] f, input logic exp_ovf, input string tag);
    l_in  = f[47:24];
    r_in  = f[23:0];
    valid = 1'b1;
    if (!exp_ovf) exp_q.push_back(f);
    @(posedge clk);
    #1;
    chk(tag, {63'h0, ovf}, {63'h0, exp_ovf});
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ws_fall(output int at_cyc);
    logic p;
    p = ws;
    at_cyc = -1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (p === 1'b1 && ws === 1'b0) begin
        at_cyc = cyc;
        break;
      end
      p = ws;
    end
    total++;
    assert (at_cyc >= 0) else begin
      bad++;
      $error("FAIL ws_fall_wait: got timeout want ws falling edge");
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic bck_period(output int per);
    logic p;
    int   first;
    first = -1;
    per   = -1;
    p     = bck;
    for (int n = 0; n < 64 && per < 0; n++) begin
      @(negedge clk);
      if (!p && bck) begin
        if (first < 0) first = cyc;
        else per = cyc - first;
      end
      p = bck;
    end
  endtask

  localparam logic [47:0] FrA  = {24'h800001, 24'h7FFFFE};
  localparam logic [47:0] FrB  = {24'h123456, 24'hABCDEF};
  localparam logic [47:0] FrC  = {24'h00FF00, 24'hFF00FF};
  localparam logic [47:0] FrD  = {24'h555555, 24'hAAAAAA};
  localparam logic [47:0] FrE  = {24'h0F0F0F, 24'hF0F0F0};
  localparam logic [47:0] FrF  = {24'h7FFFFF, 24'h800000};
  localparam logic [47:0] FrG1 = {24'h000001, 24'hFFFFFF};
  localparam logic [47:0] FrG2 = {24'h13579B, 24'h2468AC};
  localparam logic [47:0] FrH1 = {24'hC0FFEE, 24'h00BEEF};
  localparam logic [47:0] FrH2 = {24'hFACADE, 24'h0DECAF};

  initial begin
    int rel, fs, fs2, per, u8, m0, m1;

    // Reset state and free-running muted timing
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bck", {63'h0, bck}, 64'h0);
    chk("rst_ws", {63'h0, ws}, 64'h1);
    chk("rst_data", {63'h0, sdata}, 64'h0);
    chk("rst_level", {61'h0, level}, 64'h0);
    chk("rst_ovf", {63'h0, ovf}, 64'h0);
    chk("rst_unf", {63'h0, unf}, 64'h0);
    rel = cyc;
    rst = 1'b0;
    wait_ws_fall(fs);
    chk("first_ws_fall_delay", 64'(fs - rel), 64'd8);
    bck_period(per);
    chk("bck_period", 64'(per), 64'd8);
    wait_ws_fall(fs);
    wait_ws_fall(fs2);
    chk("ws_period", 64'(fs2 - fs), 64'd512);
    chk("prime_data_zero", 64'(data_ones), 64'd0);
    chk("prime_level", {61'h0, level}, 64'h0);

    // Burst of five just after a frame start: fifth push overflows
    push(FrA, 1'b0, "burst1_ovf");
    push(FrA, 1'b0, "burst2_ovf");
    push(FrB, 1'b0, "burst3_ovf");
    push(FrC, 1'b0, "burst4_ovf");
    push(FrD, 1'b1, "burst5_ovf");
    @(negedge clk);
    chk("burst_level", {61'h0, level}, 64'd4);
    chk("burst_ovf_count", 64'(ovf_cnt), 64'd1);

    // Prime release, then a push landing exactly on the frame-start pop while full
    wait_ws_fall(fs);
    chk("run_entry_level", {61'h0, level}, 64'd3);
    push(FrE, 1'b0, "refill_ovf");
    chk("refill_level", {61'h0, level}, 64'd4);
    wait_to(fs + 510);
    chk("pre_coinc_level", {61'h0, level}, 64'd4);
    chk("pre_coinc_ws", {63'h0, ws}, 64'h1);
    wait_to(fs + 511);
    push(FrF, 1'b0, "coinc_ovf");
    chk("coinc_level", {61'h0, level}, 64'd4);
    chk("coinc_ws_fell", {63'h0, ws}, 64'h0);
    chk("coinc_ovf_count", 64'(ovf_cnt), 64'd1);

    // One push per frame keeps the FIFO topped up
    wait_ws_fall(fs);
    push(FrG1, 1'b0, "steady1_ovf");
    chk("steady1_level", {61'h0, level}, 64'd4);
    wait_ws_fall(fs);
    push(FrG2, 1'b0, "steady2_ovf");
    chk("steady2_level", {61'h0, level}, 64'd4);

    // Drain to underflow, then re-prime with two frames
    repeat (3) wait_ws_fall(fs);
    wait_ws_fall(fs);
    chk("drained_level", {61'h0, level}, 64'd0);
    chk("no_unf_yet", {63'h0, unf}, 64'h0);
    u8 = unf_cnt;
    wait_ws_fall(fs);
    chk("unf_pulse", {63'h0, unf}, 64'h1);
    m0 = mute_cnt;
    push(FrH1, 1'b0, "reprime1_ovf");
    chk("unf_count", 64'(unf_cnt - u8), 64'd1);
    wait_ws_fall(fs);
    chk("prime_hold_level", {61'h0, level}, 64'd1);
    chk("prime_hold_unf", {63'h0, unf}, 64'h0);
    push(FrH2, 1'b0, "reprime2_ovf");
    chk("reprimed_level", {61'h0, level}, 64'd2);
    wait_ws_fall(fs);
    chk("resume_level", {61'h0, level}, 64'd1);
    chk("muted_frames", 64'(mute_cnt - m0), 64'd2);
    wait_ws_fall(fs);
    chk("last_pop_level", {61'h0, level}, 64'd0);
    chk("pending_before_rst", 64'(exp_q.size()), 64'd1);

    // Reset in the middle of the right slot: frame aborted, restarts muted
    wait_to(fs + 300);
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_bck", {63'h0, bck}, 64'h0);
    chk("midrst_ws", {63'h0, ws}, 64'h1);
    chk("midrst_data", {63'h0, sdata}, 64'h0);
    chk("midrst_level", {61'h0, level}, 64'h0);
    rel = cyc;
    m1 = mute_cnt;
    rst = 1'b0;
    wait_ws_fall(fs);
    chk("midrst_first_fall", 64'(fs - rel), 64'd8);
    chk("midrst_first_data", {63'h0, sdata}, 64'h0);
    wait_ws_fall(fs);
    chk("midrst_muted_frame", 64'(mute_cnt - m1), 64'd1);
    chk("end_level", {61'h0, level}, 64'h0);
    chk("end_unf_count", 64'(unf_cnt - u8), 64'd1);
    chk("end_ovf_count", 64'(ovf_cnt), 64'd1);
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want finish before 400000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
